clk_edge_monitor: RTL and testbench

Synthesizable multi-channel edge-rate monitor for the management SoC. It samples up to NCH asynchronous, clock-like signals, such as user clock, core clock or GPIO-routed clocks, on the single system clock. It counts rising edges on every channel over a programmable gate window and latches the per-channel counts with saturation flags and range-check results. It replaces bench-side edge counting with an on-chip measurement that firmware can read back and self-check.

---
 rtl/clk_edge_monitor.sv | 209 ++++++++++++++++++++
 tb/tb_clk_edge_monitor.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_edge_monitor.sv
// ============================================================================
//  Module   : clk_edge_monitor
//  Purpose  : Multi-channel edge-rate monitor. Counts rising edges of NCH
//             asynchronous clock-like inputs over a programmable gate window
//             of system-clock cycles. Latches saturating counts, per-channel
//             overflow flags and an inclusive range check at window end.
//  Options  : CLKMON_CONT_EN - when defined, the continuous input restarts
//             the window automatically after every LATCH cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_edge_monitor #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NCH-1:0]       mon_in,
    input  logic [WIN_W-1:0]     win_len,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [CNT_W-1:0]     lim_lo,
    input  logic [CNT_W-1:0]     lim_hi,
    output logic                 busy,
    output logic                 done,
    output logic [NCH*CNT_W-1:0] counts,
    output logic [NCH-1:0]       ovf,
    output logic [NCH-1:0]       in_range
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] c_WIN_ONE = WIN_W'(1);
    localparam logic [WIN_W-1:0] c_WIN_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIN_W-1:0]   r_win;
    logic [WIN_W-1:0]   w_win_nxt;
    logic               w_load;      // start of a new window: clear live counters
    logic               w_latch;     // next cycle is LATCH: capture results now
    logic               w_count_en;
    logic               w_cont;

    logic [NCH-1:0]     r_sync1;
    logic [NCH-1:0]     r_sync2;
    logic [NCH-1:0]     r_edge;
    logic [NCH-1:0]     w_pulse;

    logic [CNT_W-1:0]   r_live     [NCH];
    logic [CNT_W-1:0]   w_live_nxt [NCH];
    logic [NCH-1:0]     r_lovf;
    logic [NCH-1:0]     w_lovf_nxt;
    logic [NCH-1:0]     w_inr;

    logic [NCH*CNT_W-1:0] r_counts;
    logic [NCH-1:0]       r_ovf;
    logic [NCH-1:0]       r_inr;

`ifdef CLKMON_CONT_EN
    assign w_cont = continuous;
`else
    // Port kept for a uniform pinout; single-shot builds never restart.
    logic w_unused_cont;
    assign w_unused_cont = continuous;
    assign w_cont        = 1'b0;
`endif

    // Two-flop synchronizer followed by an edge register per channel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= mon_in;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    assign w_pulse    = r_sync2 & ~r_edge;
    assign w_count_en = (r_state == S_RUN);

    // State and window-counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_win   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
        end
    end

    // Next-state logic: a zero-length window goes straight to LATCH
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_load      = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_win_nxt = win_len;
                    if (win_len == c_WIN_ZERO) begin
                        w_state_nxt = S_LATCH;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_win_nxt = r_win - c_WIN_ONE;
                if (r_win <= c_WIN_ONE) begin
                    w_state_nxt = S_LATCH;
                    w_latch     = 1'b1;
                end
            end
            S_LATCH: begin
                if (w_cont) begin
                    w_load    = 1'b1;
                    w_win_nxt = win_len;
                    if (win_len == c_WIN_ZERO) begin
                        w_state_nxt = S_LATCH;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Live counter update with saturation; range check on the saturated value
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_live_nxt[i] = r_live[i];
            w_lovf_nxt[i] = r_lovf[i];
            if (w_load) begin
                w_live_nxt[i] = '0;
                w_lovf_nxt[i] = 1'b0;
            end else if (w_count_en && w_pulse[i]) begin
                if (r_live[i] == c_CNT_MAX) begin
                    w_lovf_nxt[i] = 1'b1;
                end else begin
                    w_live_nxt[i] = r_live[i] + c_CNT_ONE;
                end
            end
            w_inr[i] = (lim_lo <= lim_hi) &&
                       (w_live_nxt[i] >= lim_lo) &&
                       (w_live_nxt[i] <= lim_hi);
        end
    end

    // Live counters and live overflow bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                r_live[i] <= '0;
            end
            r_lovf <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_live[i] <= w_live_nxt[i];
            end
            r_lovf <= w_lovf_nxt;
        end
    end

    // Result registers capture the final live values on entry to LATCH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_counts <= '0;
            r_ovf    <= '0;
            r_inr    <= '0;
        end else if (w_latch) begin
            for (int i = 0; i < NCH; i++) begin
                r_counts[i*CNT_W +: CNT_W] <= w_live_nxt[i];
            end
            r_ovf <= w_lovf_nxt;
            r_inr <= w_inr;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_LATCH);
    assign counts   = r_counts;
    assign ovf      = r_ovf;
    assign in_range = r_inr;

endmodule

`default_nettype wire

// File: tb/tb_clk_edge_monitor.sv
// ============================================================================
//  Module   : tb_clk_edge_monitor
//  Purpose  : Self-checking bench for clk_edge_monitor. Two instances share
//             stimulus: a 16-bit counter build and an 8-bit counter build
//             that saturates. Expected results come from counting rising
//             transitions in the recorded input history.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_edge_monitor;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  mon_in;
    logic [15:0] win_len;
    logic        start;
    logic        continuous;
    logic [15:0] lim_lo;
    logic [15:0] lim_hi;
    logic [7:0]  lim_lo8;
    logic [7:0]  lim_hi8;

    logic        busy,  done;
    logic [63:0] counts;
    logic [3:0]  ovf,   in_range;
    logic        busy8, done8;
    logic [31:0] counts8;
    logic [3:0]  ovf8,  in_range8;

    int          n_chk;
    int          n_fail;
    int          cyc;
    logic [31:0] cfg;                  // per-channel byte: 00=low FF=high FE=random else toggle half-period
    logic [3:0]  smp [0:65535];        // value seen at each rising clk edge

    typedef struct {
        int          win;
        int          lo;
        int          hi;
        logic [31:0] cfg;
        int          nom0;
        int          nom1;
        logic [3:0]  inr;
        bit          chk_inr;
        logic [3:0]  ovf8;
    } vec_t;

    vec_t tbl [6];

    assign lim_lo8 = lim_lo[7:0];
    assign lim_hi8 = lim_hi[7:0];

    clk_edge_monitor #(.NCH(4), .CNT_W(16), .WIN_W(16)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .mon_in     (mon_in),
        .win_len    (win_len),
        .start      (start),
        .continuous (continuous),
        .lim_lo     (lim_lo),
        .lim_hi     (lim_hi),
        .busy       (busy),
        .done       (done),
        .counts     (counts),
        .ovf        (ovf),
        .in_range   (in_range)
    );

    clk_edge_monitor #(.NCH(4), .CNT_W(8), .WIN_W(16)) u_dut8 (
        .clk        (clk),
        .resetn     (resetn),
        .mon_in     (mon_in),
        .win_len    (win_len),
        .start      (start),
        .continuous (continuous),
        .lim_lo     (lim_lo8),
        .lim_hi     (lim_hi8),
        .busy       (busy8),
        .done       (done8),
        .counts     (counts8),
        .ovf        (ovf8),
        .in_range   (in_range8)
    );

    always #5 clk = ~clk;

    // Input history, zero while reset holds the synchronizers clear
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            smp[cyc[15:0]] = resetn ? mon_in : 4'b0000;
            cyc++;
        end
    end

    // Monitored-signal generator
    initial begin
        int         phase [4];
        logic [7:0] code;
        mon_in = 4'b0000;
        for (int c = 0; c < 4; c++) phase[c] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                code = cfg[c*8 +: 8];
                if (code == 8'h00)      mon_in[c] = 1'b0;
                else if (code == 8'hFF) mon_in[c] = 1'b1;
                else if (code == 8'hFE) mon_in[c] = 1'($urandom_range(0, 1));
                else begin
                    phase[c]++;
                    if (phase[c] >= int'(code)) begin
                        phase[c]  = 0;
                        mon_in[c] = ~mon_in[c];
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int nom);
        n_chk++;
        if (act < nom - 1 || act > nom + 1) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d+-1", name, act, nom);
        end
    endtask

    // Rising transitions whose detect pulse falls inside the window that
    // starts at edge t0: with the three-stage front end this is history
    // index t0-1 through t0+win-2.
    function automatic int n_edges(input int ch, input int t0, input int win);
        int n = 0;
        for (int m = t0 - 1; m <= t0 + win - 2; m++) begin
            if (m >= 1 && smp[16'(m)][ch] && !smp[16'(m - 1)][ch]) n++;
        end
        return n;
    endfunction

    task automatic check_results(input string tag, input int t0, input int win,
                                 input int lo, input int hi);
        logic [63:0] e16;
        logic [31:0] e8;
        logic [3:0]  o16, o8, r16, r8;
        int          e, c16, c8, lo8, hi8;
        lo8 = lo & 255;
        hi8 = hi & 255;
        for (int ch = 0; ch < 4; ch++) begin
            e       = n_edges(ch, t0, win);
            c16     = (e > 65535) ? 65535 : e;
            c8      = (e > 255) ? 255 : e;
            o16[ch] = (e > 65535);
            o8[ch]  = (e > 255);
            r16[ch] = (lo <= hi) && (c16 >= lo) && (c16 <= hi);
            r8[ch]  = (lo8 <= hi8) && (c8 >= lo8) && (c8 <= hi8);
            e16[ch*16 +: 16] = c16[15:0];
            e8[ch*8 +: 8]    = c8[7:0];
        end
        chk({tag, ".counts"},   counts,            e16);
        chk({tag, ".ovf"},      64'(ovf),          64'(o16));
        chk({tag, ".in_range"}, 64'(in_range),     64'(r16));
        chk({tag, ".counts8"},  64'(counts8),      64'(e8));
        chk({tag, ".ovf8"},     64'(ovf8),         64'(o8));
        chk({tag, ".in_rng8"},  64'(in_range8),    64'(r8));
    endtask

    task automatic measure(input string tag, input int win, input int lo, input int hi,
                           input logic [31:0] c, input bit poke, input int nom0, input int nom1);
        int t0, dones, first;
        cfg = c;
        repeat (8) @(negedge clk);
        win_len = 16'(win);
        lim_lo  = 16'(lo);
        lim_hi  = 16'(hi);
        start   = 1'b1;
        t0      = cyc;
        dones   = 0;
        first   = -1;
        for (int i = 1; i <= win + 1; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first < 0) first = i;
            end
            if (i == 1) start = 1'b0;
            if (poke && i == win / 2)     start = 1'b1;
            if (poke && i == win / 2 + 1) start = 1'b0;
        end
        chk({tag, ".done_at"}, 64'(first), 64'(win + 1));
        chk({tag, ".n_done"},  64'(dones), 64'd1);
        chk({tag, ".done8"},   64'(done8), 64'd1);
        check_results(tag, t0, win, lo, hi);
        if (nom0 >= 0) chk_tol({tag, ".nom0"}, int'(counts[15:0]),  nom0);
        if (nom1 >= 0) chk_tol({tag, ".nom1"}, int'(counts[31:16]), nom1);
        @(negedge clk);
        chk({tag, ".busy_after"}, 64'(busy), 64'd0);
        chk({tag, ".done_after"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] c;
        int          t0, dones, first, win, lo, hi;
        bit          busy_ok;
        n_chk      = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        win_len    = '0;
        lim_lo     = '0;
        lim_hi     = '0;
        cfg        = '0;

        tbl[0] = '{1000, 240, 260, 32'hFF00_0502, 250, 100, 4'b0001, 1'b1, 4'b0000};
        tbl[1] = '{1000, 300, 200, 32'hFF00_0502, 250, 100, 4'b0000, 1'b1, 4'b0000};
        tbl[2] = '{600,  0, 65535, 32'h0000_0001, 300, 0,   4'b1111, 1'b1, 4'b0001};
        tbl[3] = '{0,    0, 5,     32'hFEFE_0102, 0,   0,   4'b1111, 1'b1, 4'b0000};
        tbl[4] = '{1,    0, 0,     32'h0000_0102, -1,  -1,  4'b0000, 1'b0, 4'b0000};
        tbl[5] = '{2,    0, 1,     32'hFEFE_FEFE, -1,  -1,  4'b0000, 1'b0, 4'b0000};

        repeat (4) @(negedge clk);
        chk("rst.busy",     64'(busy),     64'd0);
        chk("rst.done",     64'(done),     64'd0);
        chk("rst.counts",   counts,        64'd0);
        chk("rst.ovf",      64'(ovf),      64'd0);
        chk("rst.in_range", 64'(in_range), 64'd0);
        chk("rst.counts8",  64'(counts8),  64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            measure($sformatf("tbl%0d", i), tbl[i].win, tbl[i].lo, tbl[i].hi,
                    tbl[i].cfg, 1'b0, tbl[i].nom0, tbl[i].nom1);
            if (tbl[i].chk_inr) chk($sformatf("tbl%0d.inr_const", i), 64'(in_range), 64'(tbl[i].inr));
            chk($sformatf("tbl%0d.ovf8_const", i), 64'(ovf8), 64'(tbl[i].ovf8));
        end

        // Second start while busy must neither restart nor add a done
        measure("restart_mid", 300, 50, 90, 32'hFF00_0502, 1'b1, 75, 30);

        // Asynchronous abort in the middle of a 1000-cycle window
        cfg = 32'hFF00_0502;
        repeat (8) @(negedge clk);
        win_len = 16'd1000;
        lim_lo  = 16'd0;
        lim_hi  = 16'd65535;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (498) @(negedge clk);
        chk("abort.busy_before", 64'(busy), 64'd1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort.busy",     64'(busy),     64'd0);
        chk("abort.done",     64'(done),     64'd0);
        chk("abort.counts",   counts,        64'd0);
        chk("abort.ovf",      64'(ovf),      64'd0);
        chk("abort.in_range", 64'(in_range), 64'd0);
        chk("abort.counts8",  64'(counts8),  64'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        measure("post_abort", 1000, 240, 260, 32'hFF00_0502, 1'b0, 250, 100);

`ifdef CLKMON_CONT_EN
        // Back-to-back windows every 101 cycles, then one more after clearing
        cfg = 32'h0000_0002;
        repeat (8) @(negedge clk);
        win_len    = 16'd100;
        lim_lo     = 16'd20;
        lim_hi     = 16'd30;
        continuous = 1'b1;
        start      = 1'b1;
        t0         = cyc;
        for (int k = 0; k < 4; k++) begin
            dones   = 0;
            first   = -1;
            busy_ok = 1'b1;
            for (int i = 1; i <= 101; i++) begin
                @(negedge clk);
                if (done) begin
                    dones++;
                    if (first < 0) first = i;
                end
                if (!busy) busy_ok = 1'b0;
                if (i == 1) begin
                    start = 1'b0;
                    if (k == 3) continuous = 1'b0;
                end
            end
            chk($sformatf("cont%0d.done_at", k), 64'(first), 64'd101);
            chk($sformatf("cont%0d.n_done", k),  64'(dones), 64'd1);
            chk($sformatf("cont%0d.busy", k),    64'(busy_ok), 64'd1);
            check_results($sformatf("cont%0d", k), t0 + k * 101, 100, 20, 30);
            chk_tol($sformatf("cont%0d.nom0", k), int'(counts[15:0]), 25);
        end
        dones   = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busy_ok = 1'b0;
        end
        chk("cont_stop.n_done", 64'(dones),   64'd0);
        chk("cont_stop.idle",   64'(busy_ok), 64'd1);
`else
        // continuous is ignored: a single window, then idle
        continuous = 1'b1;
        measure("single_shot", 100, 20, 30, 32'h0000_0002, 1'b0, 25, -1);
        dones = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("single_shot.idle", 64'(dones), 64'd0);
        continuous = 1'b0;
`endif

        // Randomised windows, limits and channel waveforms
        for (int it = 0; it < 16; it++) begin
            int r;
            for (int ch = 0; ch < 4; ch++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      c[ch*8 +: 8] = 8'h00;
                else if (r == 1) c[ch*8 +: 8] = 8'hFF;
                else if (r == 2) c[ch*8 +: 8] = 8'hFE;
                else             c[ch*8 +: 8] = 8'(r - 2);
            end
            win = int'($urandom_range(0, 700));
            lo  = int'($urandom_range(0, 300));
            hi  = int'($urandom_range(0, 300));
            measure($sformatf("rnd%0d", it), win, lo, hi, c, 1'b0, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
